ex_muldiv: RTL and testbench



---
 rtl/md_pkg.sv | 32 +++
 rtl/md_div_core.sv | 84 ++++++++
 rtl/ex_muldiv.sv | 111 +++++++++++
 tb/tb_ex_muldiv.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states,
// and small op-class helpers used by the top and the bench.
package md_pkg;

  localparam int DIV_ITERS_DEF = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring iterative divider: one quotient bit per cycle on magnitudes, with
// sign correction and divide-by-zero override applied to the final-cycle result.
module md_div_core
  import md_pkg::*;
#(
  parameter int ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [31:0]   a_raw;
  logic          q_neg;
  logic          r_neg;
  logic          div_zero;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  assign abs_a = (is_signed && a[31]) ? -a : a;
  assign abs_b = (is_signed && b[31]) ? -b : b;

  // The partial remainder never reaches 2*divisor, so a 32-bit difference is exact when it fits.
  assign shifted  = {rem, quo[31]};
  assign fits     = shifted >= {1'b0, dvs};
  assign diff     = shifted[31:0] - dvs;
  assign rem_next = fits ? diff : shifted[31:0];
  assign quo_next = {quo[30:0], fits};

  assign done = running && (cnt == LAST) && !flush;
  assign q    = div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo_next : quo_next);
  assign r    = div_zero ? a_raw : (r_neg ? -rem_next : rem_next);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running  <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      a_raw    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      running  <= 1'b1;
      cnt      <= '0;
      rem      <= '0;
      quo      <= abs_a;
      dvs      <= abs_b;
      a_raw    <= a;
      q_neg    <= is_signed && (a[31] ^ b[31]);
      r_neg    <= is_signed && a[31];
      div_zero <= (b == 32'd0);
    end else if (running) begin
      if (flush || cnt == LAST) running <= 1'b0;
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO: stalls the pipe while an op is in
// flight and commits {hi,lo} only when the op completes unflushed.
module ex_muldiv
  import md_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        flush,
  input  logic        stall_other,
  output logic        md_stall,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_signed;

  logic        launch_mul;
  logic        launch_div;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign launch_mul = (state == ST_IDLE) && md_en && !flush && is_mul_op(md_op);
  assign launch_div = (state == ST_IDLE) && md_en && !flush && is_div_op(md_op);

  // Low 64 bits of a 64x64 product of the extended operands equal the 32x32 product.
  assign ext_a   = {{32{mul_signed & mul_a[31]}}, mul_a};
  assign ext_b   = {{32{mul_signed & mul_b[31]}}, mul_b};
  assign product = ext_a * ext_b;

  assign md_stall = (state == ST_MUL) || (state == ST_DIV) || launch_mul || launch_div;
  assign md_busy  = (state != ST_IDLE);

  md_div_core #(
    .ITERS(DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (launch_div),
    .flush    (flush),
    .is_signed(md_op == MD_DIV),
    .a        (md_a),
    .b        (md_b),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      hi         <= '0;
      lo         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch_mul) begin
            mul_a      <= md_a;
            mul_b      <= md_b;
            mul_signed <= (md_op == MD_MULT);
            state      <= ST_MUL;
          end else if (launch_div) begin
            state <= ST_DIV;
          end else if (md_en && !flush && !stall_other) begin
            if (md_op == MD_MTHI) hi <= md_a;
            if (md_op == MD_MTLO) lo <= md_a;
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            {hi, lo} <= product;
            state    <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (div_done) begin
            hi    <= div_r;
            lo    <= div_q;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The completed instruction is still on the inputs; leave without relaunching it.
          if (flush || !stall_other) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: transaction-level HI/LO model with a per-cycle compare
// process, directed literal cases, then randomized traffic.
module tb_ex_muldiv;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        md_en = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] md_a = '0;
  logic [31:0] md_b = '0;
  logic        flush = 1'b0;
  logic        stall_other = 1'b0;
  logic        md_stall;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  ex_muldiv dut (
    .clk        (clk),
    .resetn     (resetn),
    .md_en      (md_en),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .flush      (flush),
    .stall_other(stall_other),
    .md_stall   (md_stall),
    .md_busy    (md_busy),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} of a mul/div op, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] uq;
    logic [63:0] ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = '0;
    case (op)
      MD_MULT:  ref_result = 64'(sa * sb);
      MD_MULTU: ref_result = ua * ub;
      MD_DIV: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          ref_result = {sr[31:0], sq[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_result = {ur[31:0], uq[31:0]};
        end
      end
      default: ref_result = '0;
    endcase
  endfunction

  // Model: cycles left until commit, whether the completed op is still held, and HI/LO.
  int          busy_left = 0;
  bit          in_done = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_left <= 0;
      in_done   <= 1'b0;
      exp_hi    <= '0;
      exp_lo    <= '0;
    end else if (busy_left > 0) begin
      if (flush) busy_left <= 0;
      else begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          exp_hi  <= pend_hi;
          exp_lo  <= pend_lo;
          in_done <= 1'b1;
        end
      end
    end else if (in_done) begin
      if (flush || !stall_other) in_done <= 1'b0;
    end else if (md_en && !flush) begin
      if (is_mul_op(md_op) || is_div_op(md_op)) begin
        {pend_hi, pend_lo} <= ref_result(md_op, md_a, md_b);
        busy_left <= is_mul_op(md_op) ? 1 : DIV_ITERS_DEF;
      end else if (!stall_other) begin
        if (md_op == MD_MTHI) exp_hi <= md_a;
        if (md_op == MD_MTLO) exp_lo <= md_a;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit es;
    bit eb;
    if (started) begin
      es = (busy_left > 0) ||
           (!in_done && md_en && !flush && (is_mul_op(md_op) || is_div_op(md_op)));
      eb = (busy_left > 0) || in_done;
      check("cyc_hi", hi, exp_hi);
      check("cyc_lo", lo, exp_lo);
      check("cyc_stall", {31'd0, md_stall}, {31'd0, es});
      check("cyc_busy", {31'd0, md_busy}, {31'd0, eb});
    end
  end

  task automatic cyc(input bit en, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit fl, input bit so);
    @(posedge clk);
    #1;
    md_en = en; md_op = op; md_a = a; md_b = b; flush = fl; stall_other = so;
  endtask

  // Present an instruction and hold it while the unit stalls; returns stall cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    bit ended;
    ended  = 1'b0;
    stalls = 0;
    cyc(1'b1, op, a, b, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      #2;
      if (!md_stall) begin
        ended = 1'b1;
        break;
      end
      stalls++;
      cyc(1'b1, op, a, b, 1'b0, 1'b0);
    end
    if (!ended) begin
      n_vec++;
      n_err++;
      $display("FAIL run_op_timeout: op %0d still stalling after 100 cycles", op);
    end
    cyc(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
    #2;
    $display("op %0d a=%h b=%h -> hi=%h lo=%h stalls=%0d", op, a, b, hi, lo, stalls);
  endtask

  initial begin
    int s;
    logic [31:0] rb;
    #2 resetn = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, s);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_stalls", 32'(s), 32'd2);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, s);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, s);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_stalls", 32'(s), 32'd33);
    run_op(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, s);
    check("divu_lo", lo, 32'd0);
    check("divu_hi", hi, 32'h8000_0000);
    run_op(MD_DIV, 32'h1234_5678, 32'd0, s);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);
    check("div0_stalls", 32'(s), 32'd33);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // Flush during iteration 15 of a divide.
    run_op(MD_MTHI, 32'h0000_AAAA, 32'd0, s);
    run_op(MD_MTLO, 32'h0000_5555, 32'd0, s);
    cyc(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (15) cyc(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
    cyc(1'b1, MD_DIV, 32'd1000, 32'd3, 1'b1, 1'b0);
    cyc(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
    #2;
    check("flush_busy", {31'd0, md_busy}, 32'd0);
    check("flush_stall", {31'd0, md_stall}, 32'd0);
    check("flush_hi", hi, 32'h0000_AAAA);
    check("flush_lo", lo, 32'h0000_5555);
    $display("flush at div iteration 15 -> hi=%h lo=%h", hi, lo);

    // DONE held by stall_other.
    cyc(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    cyc(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b1);
      #2;
      check("done_busy", {31'd0, md_busy}, 32'd1);
      check("done_stall", {31'd0, md_stall}, 32'd0);
      check("done_lo", lo, 32'd6);
      check("done_hi", hi, 32'd0);
    end
    cyc(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    cyc(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
    #2;
    check("done_exit_busy", {31'd0, md_busy}, 32'd0);
    $display("mult 2*3 held in DONE 3 cycles -> hi=%h lo=%h", hi, lo);

    // MTLO blocked by stall_other, then written.
    cyc(1'b1, MD_MTLO, 32'h55, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, MD_MTLO, 32'h55, 32'd0, 1'b0, 1'b0);
    #2;
    check("mtlo_held_lo", lo, 32'd6);
    cyc(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
    #2;
    check("mtlo_lo", lo, 32'h55);
    $display("mtlo 0x55 with stall_other -> lo=%h", lo);

    // Asynchronous reset in the middle of a divide.
    run_op(MD_MTHI, 32'h0000_1234, 32'd0, s);
    cyc(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) cyc(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    #2;
    md_en  = 1'b0;
    resetn = 1'b0;
    #1;
    check("rstdiv_hi", hi, 32'd0);
    check("rstdiv_lo", lo, 32'd0);
    check("rstdiv_stall", {31'd0, md_stall}, 32'd0);
    check("rstdiv_busy", {31'd0, md_busy}, 32'd0);
    $display("reset mid-divu -> hi=%h lo=%h", hi, lo);
    @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 6)), $urandom, rb,
          $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
    end
    cyc(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);
    repeat (40) cyc(1'b0, MD_NONE, '0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
